alu_wb_buffer: RTL and testbench
================================

Name: alu_wb_buffer

Overview:
- Downstream stage of the 4-bit ALU.
- Captures each ALU result together with its op select and its Z/C/V/S flags into a small FIFO, then delivers entries to a consumer over a valid/ready handshake.
- Maintains an architectural flag register (NZCV-style) that is updated on every accepted ALU operation.
- Decouples the combinational ALU from a slower writeback/consumer.

Parameters:
- DEPTH, 4, number of FIFO entries; power of 2, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ALU output is valid this cycle.
- in_ready  out  1  buffer can accept an entry.
- in_select  in  2  ALU op (00 add, 01 sub, 10 and, 11 or).
- in_result  in  4  ALU result.
- in_flags  in  4  ALU flags {Z,C,V,S}, bit3 = Z.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head entry.
- out_select  out  2  head entry op.
- out_result  out  4  head entry result.
- out_flags  out  4  head entry flags {Z,C,V,S} as captured.
- flags_q  out  4  architectural flag register {Z,C,V,S}.
- count  out  CNT_W  current occupancy.
- ovf_sticky  out  1  sticky overflow; see Optional Feature.
- ovf_clr  in  1  clears ovf_sticky.

Behaviour:
- Reset (rst=1 at a rising edge of clk): rd/wr pointers=0, count=0, flags_q=4'b0000, ovf_sticky=0. All stored entries are discarded, including mid-transfer. While rst is asserted, in_ready=0 and out_valid=0.
- Push: occurs when in_valid & in_ready. in_ready = (count != DEPTH); it is registered-state based and does not depend on out_ready, so there is no pass-through when full.
- Pop: occurs when out_valid & out_ready. out_valid = (count != 0).
- Latency: an entry pushed in cycle N is visible on out_* in cycle N+1 at the earliest. No combinational path from in_* to out_*.
- Empty: out_select, out_result and out_flags drive 0.
- Non-empty: out_* show the head entry. They remain stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop, count in 1..DEPTH-1: both occur and count is unchanged.
- Full (count=DEPTH): push is refused and in_valid is ignored. A pop the same cycle frees a slot for the next cycle only.
- Empty with in_valid=1: push occurs; out_valid rises the next cycle.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH. count tracks full/empty.
- Flag register: updated only on push, in the same edge.
  - Z is always loaded from in_flags[3].
  - If in_select[1]==0 (add/sub), C, V and S are loaded from in_flags.
  - If in_select[1]==1 (and/or), C, V and S retain their previous values.
- No push means flags_q holds.
- Captured entry flags (out_flags) are stored unmodified, exactly as presented.

Optional Feature:
- Macro: ALU_WB_STICKY_OVF_EN.
- Defined:
  - ovf_sticky is set on any push with in_select[1]==0 and in_flags[1]==1 (V).
  - It is cleared by ovf_clr=1.
  - If set and clear occur in the same cycle, set wins.
  - It holds otherwise and resets to 0.
- Not defined: ovf_sticky is tied to 0, ovf_clr is ignored, and no extra flop is synthesized.
- Port list is identical in both builds.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [1:0] alu_op_e: OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11.
  - typedef struct packed alu_flags_t {z,c,v,s}.
  - Constants FLAG_Z=3, FLAG_C=2, FLAG_V=1, FLAG_S=0.
  - Constant ALU_W=4.
- One sub-module, alu_wb_fifo: a generic synchronous FIFO (WIDTH, DEPTH) holding the 10-bit packed {select, result, flags}.
- The flag register and sticky logic stay in the top module.

Test Plan:
- Reset then idle:
  - Immediately after reset: count=0, out_valid=0, out_result=0, flags_q=0000, in_ready=1.
  - If rst is asserted with 3 entries held, all entries are dropped the next cycle.
- Single push:
  - Stimulus: sel=00, result=4'h9, flags=0011, out_ready=0.
  - Next cycle: out_valid=1, out_result=9, out_flags=0011, flags_q=0011, count=1.
- Fill to full:
  - Stimulus: 5 pushes with out_ready=0 and results 1, 2, 3, 4, 5.
  - Required: count=4, in_ready=0, 5th entry dropped; draining yields 1, 2, 3, 4 in order, then out_valid=0.
- Logic-op flag retention:
  - Stimulus: push sub with flags 0111, then push and with flags 1000.
  - Required: flags_q goes to 0111, then 1111 (Z loaded; C, V, S kept).
- Concurrent push and pop at count=2 for 4 cycles:
  - Required: count stays 2, FIFO order preserved, pointers wrap correctly.
- ALU_WB_STICKY_OVF_EN defined:
  - Stimulus: add with V=1 sets ovf_sticky; an or op with in_flags V=1 does not set it.
  - Required: ovf_clr together with an overflowing push leaves ovf_sticky=1; ovf_clr alone clears it to 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and constants for the writeback buffer
//
// Purpose : op-select encoding, packed flag layout {Z,C,V,S} and flag bit
//           positions used by the ALU writeback buffer and its FIFO.
// Ports   : none (package).
package alu_pkg;

    localparam int ALU_W  = 4;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_S = 0;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic z;
        logic c;
        logic v;
        logic s;
    } alu_flags_t;

endpackage

// File: rtl/alu_wb_fifo.sv
// rtl/alu_wb_fifo.sv - generic synchronous FIFO with stream handshakes
//
// Purpose : DEPTH-entry storage between the ALU and its consumer. Ready and
//           valid come only from registered occupancy, so there is no
//           combinational path from the write side to the read side.
// Ports   : clk, rst (sync, active-high)
//           s_tvalid/s_tready/s_tdata : write side
//           m_tvalid/m_tready/m_tdata : read side, m_tdata is 0 when empty
//           count                     : current occupancy
module alu_wb_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    // Both handshakes are forced low while reset is held so a transfer in
    // flight cannot complete in the reset cycle.
    assign s_tready = !rst && (count_q != CNT_W'(DEPTH));
    assign m_tvalid = !rst && (count_q != '0);
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;
    assign m_tdata  = m_tvalid ? mem_q[rd_ptr_q] : '0;
    assign count    = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = s_tdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: a zero count already marks every slot stale.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/alu_wb_buffer.sv
// rtl/alu_wb_buffer.sv - ALU writeback buffer with architectural flag register
//
// Purpose : captures {select, result, flags} from the 4-bit ALU into a FIFO,
//           hands entries to a consumer, and keeps the NZCV-style flag
//           register up to date on every accepted operation.
// Ports   : clk, rst (sync, active-high)
//           in_valid/in_ready, in_select, in_result, in_flags : ALU side
//           out_valid/out_ready, out_select, out_result, out_flags : consumer
//           flags_q    : architectural flags {Z,C,V,S}
//           count      : FIFO occupancy
//           ovf_sticky, ovf_clr : sticky overflow and its clear
// Config  : ALU_WB_STICKY_OVF_EN enables the sticky overflow flop; without it
//           ovf_sticky is tied low and ovf_clr is ignored.
module alu_wb_buffer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_select,
    input  logic [ALU_W-1:0] in_result,
    input  logic [3:0]       in_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_select,
    output logic [ALU_W-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] count,
    output logic             ovf_sticky,
    input  logic             ovf_clr
);

    localparam int ENTRY_W = 2 + ALU_W + 4;

    logic [ENTRY_W-1:0] rd_entry;
    logic               push;
    logic               is_logic_op;
    alu_op_e            in_op;
    alu_flags_t         in_f;
    alu_flags_t         flags_d;

    alu_wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (in_valid),
        .s_tready (in_ready),
        .s_tdata  ({in_select, in_result, in_flags}),
        .m_tvalid (out_valid),
        .m_tready (out_ready),
        .m_tdata  (rd_entry),
        .count    (count)
    );

    assign {out_select, out_result, out_flags} = rd_entry;

    assign push        = in_valid && in_ready;
    assign in_op       = alu_op_e'(in_select);
    assign is_logic_op = (in_op == OP_AND) || (in_op == OP_OR);
    assign in_f        = in_flags;

    // Logic ops only produce a meaningful Z; carry, overflow and sign from
    // the last arithmetic op are preserved across them.
    always_comb begin
        flags_d = flags_q;
        if (push) begin
            flags_d.z = in_f.z;
            if (!is_logic_op) begin
                flags_d.c = in_f.c;
                flags_d.v = in_f.v;
                flags_d.s = in_f.s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

`ifdef ALU_WB_STICKY_OVF_EN
    logic ovf_sticky_q, ovf_sticky_d;

    // Setting takes priority so an overflow coinciding with a clear is kept.
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        if (push && !is_logic_op && in_flags[FLAG_V]) begin
            ovf_sticky_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky_q <= 1'b0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign ovf_sticky = ovf_sticky_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_wb_buffer.sv
// tb/tb_alu_wb_buffer.sv - randomized self-checking bench for alu_wb_buffer
module tb_alu_wb_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_select;
    logic [3:0]       in_result;
    logic [3:0]       in_flags;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_select;
    logic [3:0]       out_result;
    logic [3:0]       out_flags;
    logic [3:0]       flags_q;
    logic [CNT_W-1:0] count;
    logic             ovf_sticky;
    logic             ovf_clr;

    alu_wb_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_select  (in_select),
        .in_result  (in_result),
        .in_flags   (in_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_select (out_select),
        .out_result (out_result),
        .out_flags  (out_flags),
        .flags_q    (flags_q),
        .count      (count),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: a queue of {select, result, flags} entries.
    logic [9:0] m_q[$];
    logic [3:0] m_flags  = 4'b0000;
    logic       m_sticky = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input logic v, input logic [1:0] sel, input logic [3:0] res,
                         input logic [3:0] fl, input logic ordy, input logic clr,
                         input logic r, input bit chk);
        logic       e_ready, e_valid, do_push, do_pop;
        logic [9:0] head;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        in_select = sel;
        in_result = res;
        in_flags  = fl;
        out_ready = ordy;
        ovf_clr   = clr;
        e_ready   = !r && (m_q.size() < DEPTH);
        e_valid   = !r && (m_q.size() > 0);
        head      = e_valid ? m_q[0] : 10'd0;
        #1;
        if (chk) begin
            check("in_ready",   32'(in_ready),   32'(e_ready));
            check("out_valid",  32'(out_valid),  32'(e_valid));
            check("count",      32'(count),      32'(m_q.size()));
            check("out_select", 32'(out_select), 32'(head[9:8]));
            check("out_result", 32'(out_result), 32'(head[7:4]));
            check("out_flags",  32'(out_flags),  32'(head[3:0]));
            check("flags_q",    32'(flags_q),    32'(m_flags));
            check("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
        end
        do_push = v && e_ready;
        do_pop  = ordy && e_valid;
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_flags  = 4'b0000;
            m_sticky = 1'b0;
        end else begin
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back({sel, res, fl});
                // Z always follows the ALU; C/V/S only follow add and sub.
                m_flags = (sel >= 2'd2) ? {fl[3], m_flags[2:0]} : fl;
            end
`ifdef ALU_WB_STICKY_OVF_EN
            if (do_push && sel < 2'd2 && fl[1]) m_sticky = 1'b1;
            else if (clr) m_sticky = 1'b0;
`endif
        end
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 2'b00, 4'h0, 4'h0, ordy, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic push(input logic [1:0] sel, input logic [3:0] res,
                        input logic [3:0] fl, input logic ordy);
        cycle(1'b1, sel, res, fl, ordy, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        // Power-up: state unknown until the first reset edge.
        cycle(1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1'b0);

        // Reset drops three held entries.
        push(2'b00, 4'h1, 4'h0, 1'b0);
        push(2'b01, 4'h2, 4'h4, 1'b0);
        push(2'b10, 4'h3, 4'h8, 1'b0);
        cycle(1'b1, 2'b00, 4'h4, 4'h2, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(1'b0);

        // Single push, visible the following cycle.
        push(2'b00, 4'h9, 4'b0011, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Fill to full; the fifth push is refused, then drain in order.
        for (int i = 1; i <= 5; i++) push(2'b00, 4'(i), 4'(i), 1'b0);
        idle(1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Logic op keeps C/V/S and loads Z.
        push(2'b01, 4'h6, 4'b0111, 1'b1);
        push(2'b10, 4'h0, 4'b1000, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Concurrent push and pop at count 2, pointers wrap.
        push(2'b00, 4'hA, 4'h1, 1'b0);
        push(2'b01, 4'hB, 4'h2, 1'b0);
        for (int i = 0; i < 4; i++) push(2'b11, 4'(12 + i), 4'(i), 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Sticky overflow: or with V does not set, add with V sets,
        // clear with overflowing push keeps it, clear alone drops it.
        push(2'b11, 4'h1, 4'b0010, 1'b1);
        idle(1'b1);
        push(2'b00, 4'h2, 4'b0010, 1'b1);
        idle(1'b1);
        cycle(1'b1, 2'b01, 4'h3, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        cycle(1'b0, 2'b00, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(1'b1);

        // Full with simultaneous pop: the slot frees only for next cycle.
        for (int i = 0; i < 4; i++) push(2'b00, 4'(i), 4'h0, 1'b0);
        push(2'b01, 4'hF, 4'hF, 1'b1);
        push(2'b01, 4'hE, 4'hE, 1'b0);
        idle(1'b0);

        // Random traffic with occasional resets and clears.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom), 4'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 60) == 0), 1'b1);
        end
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
